// File: rtl/rvfi_harness_pkg.sv
// Shared types and constants for the RVFI check sequencer.
// Contents: FSM state type, RV32I opcode constants, order width,
// and an RV32I encoding-legality helper used by the instruction filter.
package rvfi_harness_pkg;

    localparam int unsigned ORDER_W = 64;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    // True when the word is a defined RV32I base encoding.
    function automatic logic rv32i_legal(input logic [31:0] insn);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       legal;
        opc   = insn[6:0];
        f3    = insn[14:12];
        f7    = insn[31:25];
        legal = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
            OPC_JALR:     legal = (f3 == 3'b000);
            OPC_BRANCH:   legal = (f3 != 3'b010) && (f3 != 3'b011);
            OPC_LOAD:     legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            OPC_STORE:    legal = f3 inside {3'b000, 3'b001, 3'b010};
            OPC_OP_IMM: begin
                if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else                   legal = 1'b1;
            end
            OPC_OP:       legal = (f7 == 7'b0000000) ||
                                  ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
            OPC_MISC_MEM: legal = (f3 == 3'b000);
            OPC_SYSTEM:   legal = (f3 != 3'b100);
            default:      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rvfi_insn_filter.sv
// Per-channel instruction filter: passes idle channels, and valid channels
// that retired cleanly with a legal non-memory, non-system RV32I instruction.
// Ports: valid/trap/halt/intr (status), insn (low 32 bits of the word), ok (comb result).
module rvfi_insn_filter
    import rvfi_harness_pkg::*;
(
    input  logic        valid,
    input  logic        trap,
    input  logic        halt,
    input  logic        intr,
    input  logic [31:0] insn,
    output logic        ok
);

    logic [6:0] opcode;
    logic       excluded;

    assign opcode   = insn[6:0];
    assign excluded = (opcode == OPC_SYSTEM) || (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    assign ok       = !valid || (!trap && !halt && !intr && !excluded && rv32i_legal(insn));

endmodule

// File: rtl/rvfi_check_sequencer.sv
// Formal-harness sequencer: holds the core in reset for RESET_CYCLES after
// release, pulses check_enable once at CHECK_CYCLE, counts cycles and
// retirements, and flags out-of-order or non-contiguous RVFI retirement.
// Ports: clk, reset (async, active-high); rvfi_* retire inputs per channel;
// core_reset, check_enable, cycle, retire_cnt, order_err (registered);
// insn_ok (combinational per-channel filter result).
// Optional feature: define RISCV_FORMAL_INSN_FILTER_EN to enable the
// instruction filter; otherwise insn_ok is all-ones.
module rvfi_check_sequencer
    import rvfi_harness_pkg::*;
#(
    parameter int unsigned NRET         = 1,
    parameter int unsigned ILEN         = 32,
    parameter int unsigned RESET_CYCLES = 5,
    parameter int unsigned CHECK_CYCLE  = 20,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NRET-1:0]         rvfi_valid,
    input  logic [NRET*ORDER_W-1:0] rvfi_order,
    input  logic [NRET*ILEN-1:0]    rvfi_insn,
    input  logic [NRET-1:0]         rvfi_trap,
    input  logic [NRET-1:0]         rvfi_halt,
    input  logic [NRET-1:0]         rvfi_intr,
    output logic                    core_reset,
    output logic                    check_enable,
    output logic [CNT_W-1:0]        cycle,
    output logic [CNT_W-1:0]        retire_cnt,
    output logic                    order_err,
    output logic [NRET-1:0]         insn_ok
);

    localparam int unsigned PC_W = $clog2(NRET + 1);

    // Parameter sanity checks at elaboration.
    if (CHECK_CYCLE <= RESET_CYCLES) begin : g_bad_check_cycle
        $error("CHECK_CYCLE must be greater than RESET_CYCLES");
    end
    if (((64'd1 << CNT_W) - 64'd1) <= 64'(CHECK_CYCLE)) begin : g_bad_cnt_w
        $error("CNT_W too narrow: 2**CNT_W-1 must exceed CHECK_CYCLE");
    end

    state_t               state;
    state_t               state_d;
    logic                 core_reset_d;
    logic                 check_enable_d;
    logic [ORDER_W-1:0]   next_order;
    logic [PC_W-1:0]      pop;
    logic                 gap;
    logic                 mismatch;
    logic [CNT_W:0]       ret_sum;

    // Saturating free-running cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle <= '0;
        end else if (cycle != '1) begin
            cycle <= cycle + CNT_W'(1);
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_RESET;
            core_reset   <= 1'b1;
            check_enable <= 1'b0;
        end else begin
            state        <= state_d;
            core_reset   <= core_reset_d;
            check_enable <= check_enable_d;
        end
    end

    // Next state; outputs are decoded from the next state so they line up
    // with the cycle value the state is entered on.
    always_comb begin
        state_d = state;
        case (state)
            S_RESET: if (cycle == CNT_W'(RESET_CYCLES - 1)) state_d = S_RUN;
            S_RUN:   if (cycle == CNT_W'(CHECK_CYCLE - 1))  state_d = S_CHECK;
            S_CHECK: state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_RESET;
        endcase
        core_reset_d   = (state_d == S_RESET);
        check_enable_d = (state_d == S_CHECK);
    end

    // Retirement checks for the current cycle.
    always_comb begin
        pop      = '0;
        gap      = 1'b0;
        mismatch = 1'b0;
        for (int unsigned i = 0; i < NRET; i++) begin
            pop = pop + PC_W'(rvfi_valid[i]);
            if (rvfi_valid[i] &&
                (rvfi_order[i*ORDER_W +: ORDER_W] != next_order + ORDER_W'(i))) begin
                mismatch = 1'b1;
            end
        end
        // Any 0->1 step going up the channels means a hole below a valid slot.
        for (int unsigned i = 1; i < NRET; i++) begin
            if (rvfi_valid[i] && !rvfi_valid[i-1]) begin
                gap = 1'b1;
            end
        end
        ret_sum = {1'b0, retire_cnt} + (CNT_W + 1)'(pop);
    end

    // Order tracker; RVFI is ignored while the core is held in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_order <= '0;
            retire_cnt <= '0;
            order_err  <= 1'b0;
        end else if (!core_reset) begin
            next_order <= next_order + ORDER_W'(pop);
            retire_cnt <= ret_sum[CNT_W] ? '1 : ret_sum[CNT_W-1:0];
            if (gap || mismatch) begin
                order_err <= 1'b1;
            end
        end
    end

`ifdef RISCV_FORMAL_INSN_FILTER_EN
    for (genvar g = 0; g < NRET; g++) begin : g_filter
        rvfi_insn_filter u_filter (
            .valid (rvfi_valid[g]),
            .trap  (rvfi_trap[g]),
            .halt  (rvfi_halt[g]),
            .intr  (rvfi_intr[g]),
            .insn  (rvfi_insn[g*ILEN +: 32]),
            .ok    (insn_ok[g])
        );
    end
`else
    // Filter absent: status and instruction inputs are intentionally unused.
    logic unused_filter_inputs;
    assign unused_filter_inputs = ^{rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr};
    assign insn_ok = '1;
`endif

endmodule
